// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Pipeline interlock for the five-stage MIPS core. Each cycle it decides
// whether the D-stage instruction must wait. When it must, the PC and the F/D
// register are frozen and a bubble is injected into the D/E register.
//
// Stall sources, ORed together:
//   - register-operand hazards: the D-stage Tuse is compared against the
//     Tnew of the E and M stage producers;
//   - HI/LO hazard: raised while the multiply/divide unit is busy. The busy
//     counter lives in this block;
//   - eret/EPC hazard: raised while an mtc0 to EPC is still in E or M.
// An exception/interrupt flush (IntExcReq) overrides every stall, so the
// handler fetch is never blocked.
//
// Ports:
//   clk, reset                      clock (rising edge), async active-high reset
//   IntExcReq                       exception/interrupt flush this cycle
//   D_Rs, D_Rt, D_TuseRs, D_TuseRt  D-stage operand indices and Tuse (3 = unused)
//   D_IsMD, D_IsEret                D-stage instruction class
//   E_WriteAddr, E_Tnew, E_RegWrite E-stage producer
//   E_Start, E_IsDiv                mult/div start pulse in E, and div qualifier
//   E_IsMtcEpc, M_IsMtcEpc          mtc0 $14 in E / M
//   M_WriteAddr, M_Tnew, M_RegWrite M-stage producer
//   Stall                           freeze F/D, clear D/E
//   MDBusy                          multiply/divide unit busy
//   MDCount                         current busy counter (debug)
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       IntExcReq,
  input  logic [4:0] D_Rs,
  input  logic [4:0] D_Rt,
  input  logic [1:0] D_TuseRs,
  input  logic [1:0] D_TuseRt,
  input  logic       D_IsMD,
  input  logic       D_IsEret,
  input  logic [4:0] E_WriteAddr,
  input  logic [1:0] E_Tnew,
  input  logic       E_RegWrite,
  input  logic       E_Start,
  input  logic       E_IsDiv,
  input  logic       E_IsMtcEpc,
  input  logic [4:0] M_WriteAddr,
  input  logic [1:0] M_Tnew,
  input  logic       M_RegWrite,
  input  logic       M_IsMtcEpc,
  output logic       Stall,
  output logic       MDBusy,
  output logic [3:0] MDCount
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic       haz_rs;
  logic       haz_rt;
  logic       haz_md;
  logic       haz_eret;
  logic       e_start_eff;
  logic [3:0] md_count_d;
  logic [3:0] md_count_q;

  // ---------------------------------------------------------------------------
  // Register-operand hazards.
  // A producer blocks the consumer when it targets the same register and its
  // result arrives later than the consumer needs it (Tuse < Tnew). Tuse = 3
  // (operand unused) can never be below Tnew, which is at most 2. Register $0
  // is hard-wired to zero and is never a real dependency.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in this block gets a default first, so no
    // path through it can leave a value unassigned and infer a latch.
    haz_rs = 1'b0;
    haz_rt = 1'b0;

    if (D_Rs != 5'd0) begin
      if (E_RegWrite && (E_WriteAddr == D_Rs) && (D_TuseRs < E_Tnew))
        haz_rs = 1'b1;
      if (M_RegWrite && (M_WriteAddr == D_Rs) && (D_TuseRs < M_Tnew))
        haz_rs = 1'b1;
    end

    if (D_Rt != 5'd0) begin
      if (E_RegWrite && (E_WriteAddr == D_Rt) && (D_TuseRt < E_Tnew))
        haz_rt = 1'b1;
      if (M_RegWrite && (M_WriteAddr == D_Rt) && (D_TuseRt < M_Tnew))
        haz_rt = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Multiply/divide busy tracking.
  // A start in E during a flush belongs to an instruction that is being
  // discarded, so it is suppressed. An operation that is already counting was
  // started by an older, committed instruction and runs to completion.
  // ---------------------------------------------------------------------------
  assign e_start_eff = E_Start & ~IntExcReq;

  always_comb begin
    md_count_d = md_count_q;
    if (e_start_eff)
      md_count_d = E_IsDiv ? DIV_LOAD : MULT_LOAD;
    else if (md_count_q != 4'd0)
      md_count_d = md_count_q - 4'd1;
  end

  // The counter has no reset-free storage, so an async clear is cheap and it
  // lets a mid-operation reset drop MDBusy without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value regardless of block ordering.
    if (reset)
      md_count_q <= 4'd0;
    else
      md_count_q <= md_count_d;
  end

  // The start cycle is busy too, because the counter still shows 0 then.
  assign MDBusy  = e_start_eff | (md_count_q != 4'd0);
  assign MDCount = md_count_q;
  assign haz_md  = D_IsMD & MDBusy;

  // ---------------------------------------------------------------------------
  // eret reads EPC in D, so it must wait until any mtc0 to EPC still in flight
  // in E or M has been written.
  // ---------------------------------------------------------------------------
  assign haz_eret = D_IsEret & (E_IsMtcEpc | M_IsMtcEpc);

  // A flush redirects the PC to the handler and must never be held off.
  assign Stall = (haz_rs | haz_rt | haz_md | haz_eret) & ~IntExcReq;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for hazard_stall_ctrl. Inputs are driven 1 time unit
// after a rising edge and outputs are checked 1 time unit later, well before
// the next edge. Expected values are written out by hand from the block's
// intended behaviour.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       IntExcReq;
  logic [4:0] D_Rs, D_Rt;
  logic [1:0] D_TuseRs, D_TuseRt;
  logic       D_IsMD, D_IsEret;
  logic [4:0] E_WriteAddr;
  logic [1:0] E_Tnew;
  logic       E_RegWrite, E_Start, E_IsDiv, E_IsMtcEpc;
  logic [4:0] M_WriteAddr;
  logic [1:0] M_Tnew;
  logic       M_RegWrite, M_IsMtcEpc;
  logic       Stall, MDBusy;
  logic [3:0] MDCount;

  int vectors     = 0;
  int miscompares = 0;

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .IntExcReq(IntExcReq),
    .D_Rs(D_Rs), .D_Rt(D_Rt), .D_TuseRs(D_TuseRs), .D_TuseRt(D_TuseRt),
    .D_IsMD(D_IsMD), .D_IsEret(D_IsEret),
    .E_WriteAddr(E_WriteAddr), .E_Tnew(E_Tnew), .E_RegWrite(E_RegWrite),
    .E_Start(E_Start), .E_IsDiv(E_IsDiv), .E_IsMtcEpc(E_IsMtcEpc),
    .M_WriteAddr(M_WriteAddr), .M_Tnew(M_Tnew), .M_RegWrite(M_RegWrite),
    .M_IsMtcEpc(M_IsMtcEpc),
    .Stall(Stall), .MDBusy(MDBusy), .MDCount(MDCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] observed,
                       input logic [3:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Bring every input to its quiet value: no producers, operands unused.
  task automatic idle();
    IntExcReq   = 1'b0;
    D_Rs        = 5'd0;  D_Rt     = 5'd0;
    D_TuseRs    = 2'd3;  D_TuseRt = 2'd3;
    D_IsMD      = 1'b0;  D_IsEret = 1'b0;
    E_WriteAddr = 5'd0;  E_Tnew   = 2'd0;  E_RegWrite = 1'b0;
    E_Start     = 1'b0;  E_IsDiv  = 1'b0;  E_IsMtcEpc = 1'b0;
    M_WriteAddr = 5'd0;  M_Tnew   = 2'd0;  M_RegWrite = 1'b0;
    M_IsMtcEpc  = 1'b0;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #2;
    check("reset_count", MDCount, 4'd0);
    check("reset_busy",  {3'd0, MDBusy}, 4'd0);
    check("reset_stall", {3'd0, Stall},  4'd0);
    step();
    reset = 1'b0;

    // ---- load-use: lw $8 in E, consumer of $8 in D ---------------------------
    step(); idle();
    E_WriteAddr = 5'd8; E_Tnew = 2'd2; E_RegWrite = 1'b1;
    D_Rs = 5'd8; D_TuseRs = 2'd0;
    #1 check("lu_e_tnew2", {3'd0, Stall}, 4'd1);
    step();
    E_RegWrite = 1'b0; E_WriteAddr = 5'd0; E_Tnew = 2'd0;
    M_WriteAddr = 5'd8; M_Tnew = 2'd1; M_RegWrite = 1'b1;
    #1 check("lu_m_tnew1", {3'd0, Stall}, 4'd1);
    step();
    M_Tnew = 2'd0;
    #1 check("lu_m_tnew0", {3'd0, Stall}, 4'd0);

    // ---- $0 and unused operands ---------------------------------------------
    step(); idle();
    E_WriteAddr = 5'd0; E_Tnew = 2'd2; E_RegWrite = 1'b1;
    D_Rs = 5'd0; D_TuseRs = 2'd0;
    #1 check("zero_reg", {3'd0, Stall}, 4'd0);
    step(); idle();
    E_WriteAddr = 5'd9; E_Tnew = 2'd2; E_RegWrite = 1'b1;
    D_Rt = 5'd9; D_TuseRt = 2'd3;
    #1 check("rt_unused", {3'd0, Stall}, 4'd0);
    D_TuseRt = 2'd1;
    #1 check("rt_tuse1_tnew2", {3'd0, Stall}, 4'd1);
    D_TuseRt = 2'd2;
    #1 check("rt_tuse2_tnew2", {3'd0, Stall}, 4'd0);
    D_TuseRt = 2'd1; IntExcReq = 1'b1;
    #1 check("rt_flush_wins", {3'd0, Stall}, 4'd0);

    // ---- div sequence ---------------------------------------------------------
    step(); idle();
    E_Start = 1'b1; E_IsDiv = 1'b1;
    #1 check("div_start_busy",  {3'd0, MDBusy}, 4'd1);
    check("div_start_count", MDCount, 4'd0);
    check("div_start_stall", {3'd0, Stall}, 4'd0);
    for (int k = 1; k <= 11; k++) begin
      step();
      E_Start = 1'b0; E_IsDiv = 1'b0; D_IsMD = 1'b1;
      #1 check($sformatf("div_count_t%0d", k), MDCount, 4'(11 - k));
      check($sformatf("div_stall_t%0d", k), {3'd0, Stall}, (k <= 10) ? 4'd1 : 4'd0);
    end
    step();
    check("div_count_hold0", MDCount, 4'd0);

    // ---- mult sequence --------------------------------------------------------
    step(); idle();
    E_Start = 1'b1; E_IsDiv = 1'b0;
    #1 check("mult_start_busy", {3'd0, MDBusy}, 4'd1);
    for (int k = 1; k <= 6; k++) begin
      step();
      E_Start = 1'b0; D_IsMD = 1'b1;
      #1 check($sformatf("mult_count_t%0d", k), MDCount, 4'(6 - k));
      check($sformatf("mult_stall_t%0d", k), {3'd0, Stall}, (k <= 5) ? 4'd1 : 4'd0);
    end

    // ---- flush interplay ------------------------------------------------------
    step(); idle();
    E_Start = 1'b1; E_IsDiv = 1'b1; IntExcReq = 1'b1;
    #1 check("flush_start_busy", {3'd0, MDBusy}, 4'd0);
    step(); idle();
    #1 check("flush_start_count", MDCount, 4'd0);

    E_Start = 1'b1; E_IsDiv = 1'b0;            // mult: 5 after next edge
    step(); idle();
    step();
    #1 check("flush_pre_count4", MDCount, 4'd4);
    IntExcReq = 1'b1; D_IsMD = 1'b1;
    #1 check("flush_stall_low", {3'd0, Stall}, 4'd0);
    check("flush_busy_kept", {3'd0, MDBusy}, 4'd1);
    step();
    IntExcReq = 1'b0;
    #1 check("flush_count3", MDCount, 4'd3);
    for (int k = 0; k < 3; k++) step();
    idle();

    // ---- eret / EPC -----------------------------------------------------------
    step(); idle();
    D_IsEret = 1'b1; E_IsMtcEpc = 1'b1;
    #1 check("eret_e", {3'd0, Stall}, 4'd1);
    step();
    E_IsMtcEpc = 1'b0; M_IsMtcEpc = 1'b1;
    #1 check("eret_m", {3'd0, Stall}, 4'd1);
    step();
    M_IsMtcEpc = 1'b0;
    #1 check("eret_clear", {3'd0, Stall}, 4'd0);

    // ---- async reset mid-count ------------------------------------------------
    step(); idle();
    E_Start = 1'b1; E_IsDiv = 1'b1;
    step(); idle();                            // 10
    step(); step(); step();                    // 9, 8, 7
    check("areset_pre_count7", MDCount, 4'd7);
    #1 reset = 1'b1;                           // between edges
    #1 check("areset_count", MDCount, 4'd0);
    check("areset_busy", {3'd0, MDBusy}, 4'd0);
    step();
    reset = 1'b0;
    step();
    check("areset_stays0", MDCount, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
